// File: rtl/arm_reg_file.sv
// ---------------------------------------------------------------------------
// arm_reg_file
//   32-entry integer register file for an ARMv8-style datapath (X0-X30 + XZR).
//   Two combinational read ports feed the ALU (BusA) and the ALUSrc mux /
//   store-data path (BusB). One write port captures the writeback value on the
//   rising clock edge. X31 (XZR) has no storage: it always reads zero and
//   writes to it are dropped.
//
// Parameters
//   WIDTH     : data width of every register and bus
//   BYPASS    : 1 = a same-cycle write to a read address is forwarded to the
//               read bus combinationally; 0 = reads return the stored value
//   RESET_VAL : value loaded into X0-X30 while Reset is high
//
// Ports
//   Clk    in   system clock, rising-edge updates
//   Reset  in   asynchronous, active-high reset
//   RA     in   [4:0]       read address, port A
//   RB     in   [4:0]       read address, port B
//   RW     in   [4:0]       write address
//   BusW   in   [WIDTH-1:0] write data
//   RegWr  in   write enable
//   BusA   out  [WIDTH-1:0] read data, port A
//   BusB   out  [WIDTH-1:0] read data, port B
//
// There is no FSM and no handshake: every read is a pure function of the
// current addresses, write-port inputs and register contents.
// ---------------------------------------------------------------------------
module arm_reg_file #(
  parameter int               WIDTH     = 64,
  parameter int               BYPASS    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  input  logic [4:0]       RW,
  input  logic [WIDTH-1:0] BusW,
  input  logic             RegWr,
  output logic [WIDTH-1:0] BusA,
  output logic [WIDTH-1:0] BusB
);

  localparam logic [4:0] XZR     = 5'd31;
  localparam int         NUM_REG = 31;

  logic [WIDTH-1:0] regs [0:NUM_REG-1];
  logic             wr_en;
  logic [WIDTH-1:0] stored_a;
  logic [WIDTH-1:0] stored_b;

  // A write is only real when not in reset and not aimed at XZR. The same
  // qualifier gates the bypass path so forwarding never shows a value that
  // will not actually be stored.
  assign wr_en = RegWr && !Reset && (RW != XZR);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REG; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REG; i++) begin
        if (RW == 5'(i)) begin
          regs[i] <= BusW;
        end
      end
    end
  end

  // Decoded read of the physical array. Address 31 matches no entry, so the
  // stored value falls back to zero without indexing past the array.
  always_comb begin
    stored_a = '0;
    stored_b = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (RA == 5'(i)) begin
        stored_a = regs[i];
      end
      if (RB == 5'(i)) begin
        stored_b = regs[i];
      end
    end
  end

  // Priority (lowest to highest): stored value, bypass, XZR force-to-zero.
  // During Reset the array already holds RESET_VAL (asynchronous load) and
  // wr_en is low, so the stored path shows RESET_VAL with bypass suppressed.
  always_comb begin
    BusA = stored_a;
    BusB = stored_b;
    if ((BYPASS != 0) && wr_en && (RA == RW)) begin
      BusA = BusW;
    end
    if ((BYPASS != 0) && wr_en && (RB == RW)) begin
      BusB = BusW;
    end
    if (RA == XZR) begin
      BusA = '0;
    end
    if (RB == XZR) begin
      BusB = '0;
    end
  end

endmodule

// File: tb/tb_arm_reg_file.sv
// ---------------------------------------------------------------------------
// tb_arm_reg_file
//   Drives two register-file instances from shared inputs:
//     dut_byp : BYPASS=1, RESET_VAL=0
//     dut_nb  : BYPASS=0, RESET_VAL=RV_N (non-zero, so XZR-vs-reset is visible)
//   Directed table of single-cycle vectors, hand-written reset sequences,
//   then a randomized run checked against an array-based reference model.
// ---------------------------------------------------------------------------
module tb_arm_reg_file;

  localparam int          W    = 64;
  localparam logic [W-1:0] RV_A = 64'h0;
  localparam logic [W-1:0] RV_N = 64'hA5A5_0000_5A5A_FFFF;

  // ---------------- clock / reset block ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   ra, rb, rw;
  logic [W-1:0] busw;
  logic         regwr;
  logic [W-1:0] busa_byp, busb_byp, busa_nb, busb_nb;

  always #5 clk = ~clk;

  arm_reg_file #(.WIDTH(W), .BYPASS(1), .RESET_VAL(RV_A)) dut_byp (
    .Clk(clk), .Reset(reset), .RA(ra), .RB(rb), .RW(rw),
    .BusW(busw), .RegWr(regwr), .BusA(busa_byp), .BusB(busb_byp)
  );

  arm_reg_file #(.WIDTH(W), .BYPASS(0), .RESET_VAL(RV_N)) dut_nb (
    .Clk(clk), .Reset(reset), .RA(ra), .RB(rb), .RW(rw),
    .BusW(busw), .RegWr(regwr), .BusA(busa_nb), .BusB(busb_nb)
  );

  // ---------------- reference model ----------------
  logic [W-1:0] model_a [0:30];
  logic [W-1:0] model_n [0:30];

  // Architectural read rule: XZR is zero; in reset show the reset value;
  // with bypass a live write to the same address is seen immediately;
  // otherwise the last value committed by an edge.
  function automatic logic [W-1:0] exp_read(input logic [4:0] addr, input bit byp);
    if (addr == 5'd31) return '0;
    if (reset) return byp ? RV_A : RV_N;
    if (byp && regwr && rw != 5'd31 && addr == rw) return busw;
    return byp ? model_a[addr] : model_n[addr];
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    logic [W-1:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, e, $time);
    end
  endtask

  task automatic check_all4(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb,
                            input logic [W-1:0] ea_nb, input logic [W-1:0] eb_nb);
    check({name, "_a_byp"}, busa_byp, ea);
    check({name, "_b_byp"}, busb_byp, eb);
    check({name, "_a_nb"},  busa_nb,  ea_nb);
    check({name, "_b_nb"},  busb_nb,  eb_nb);
  endtask

  task automatic check_model(input string name);
    check_all4(name, exp_read(ra, 1'b1), exp_read(rb, 1'b1),
               exp_read(ra, 1'b0), exp_read(rb, 1'b0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [4:0] w,
                       input logic [W-1:0] d, input logic we);
    ra = a; rb = b; rw = w; busw = d; regwr = we;
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (v) begin
      for (int i = 0; i < 31; i++) begin
        model_a[i] = RV_A;
        model_n[i] = RV_N;
      end
    end
  endtask

  // Commit the model for the coming edge, then step to 1 ns past it.
  task automatic edge_step();
    if (!reset && regwr && rw != 5'd31) begin
      model_a[rw] = busw;
      model_n[rw] = busw;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string        name;
    logic [4:0]   ra, rb, rw;
    logic [W-1:0] busw;
    logic         regwr;
    logic [W-1:0] ea, eb, ea_nb, eb_nb;
  } vec_t;

  localparam logic [W-1:0] DB = 64'hDEAD_BEEF_0123_4567;
  localparam logic [W-1:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{"wr_x5",     5'd5,  5'd6,  5'd5,  DB,     1'b1, DB,     64'h0,  RV_N,   RV_N};
    vecs[1]  = '{"wr_x6",     5'd5,  5'd6,  5'd6,  64'h1,  1'b1, DB,     64'h1,  DB,     RV_N};
    vecs[2]  = '{"rd_x5x6",   5'd5,  5'd6,  5'd5,  FF,     1'b0, DB,     64'h1,  DB,     64'h1};
    vecs[3]  = '{"rest",      5'd0,  5'd30, 5'd0,  FF,     1'b0, 64'h0,  64'h0,  RV_N,   RV_N};
    vecs[4]  = '{"xzr_wr",    5'd31, 5'd5,  5'd31, FF,     1'b1, 64'h0,  DB,     64'h0,  DB};
    vecs[5]  = '{"xzr_after", 5'd31, 5'd6,  5'd31, FF,     1'b1, 64'h0,  64'h1,  64'h0,  64'h1};
    vecs[6]  = '{"x7_init",   5'd7,  5'd7,  5'd7,  64'h10, 1'b1, 64'h10, 64'h10, RV_N,   RV_N};
    vecs[7]  = '{"bypass",    5'd7,  5'd0,  5'd7,  64'h20, 1'b1, 64'h20, 64'h0,  64'h10, RV_N};
    vecs[8]  = '{"post_byp",  5'd7,  5'd5,  5'd7,  64'h30, 1'b0, 64'h20, DB,     64'h20, DB};
    vecs[9]  = '{"same_addr", 5'd6,  5'd6,  5'd8,  64'h99, 1'b1, 64'h1,  64'h1,  64'h1,  64'h1};
    vecs[10] = '{"x8_rd",     5'd8,  5'd31, 5'd8,  64'h0,  1'b0, 64'h99, 64'h0,  64'h99, 64'h0};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [4:0]   a, b, w;
    logic [W-1:0] d;

    // Initial reset, with a would-be write active: bypass must stay off.
    set_reset(1'b1);
    drive(5'd4, 5'd31, 5'd4, 64'hBAD, 1'b1);
    #2;
    check_all4("reset_init", 64'h0, 64'h0, RV_N, 64'h0);
    edge_step();
    set_reset(1'b0);
    drive(5'd0, 5'd0, 5'd0, '0, 1'b0);
    #1;
    check_all4("reset_x4_kept", 64'h0, 64'h0, RV_N, RV_N);
    edge_step();

    // Directed table: check before the edge, then commit.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].ra, vecs[i].rb, vecs[i].rw, vecs[i].busw, vecs[i].regwr);
      #1;
      check_all4(vecs[i].name, vecs[i].ea, vecs[i].eb, vecs[i].ea_nb, vecs[i].eb_nb);
      edge_step();
    end

    // Asynchronous reset pulse mid-cycle, no clock edge while high.
    drive(5'd5, 5'd6, 5'd0, '0, 1'b0);
    #2;
    set_reset(1'b1);
    #1;
    check_all4("async_rst", 64'h0, 64'h0, RV_N, RV_N);
    set_reset(1'b0);
    for (int i = 0; i < 32; i++) begin
      drive(5'(i), 5'(31 - i), 5'd0, '0, 1'b0);
      #1;
      check_model("async_rst_scan");
    end
    @(posedge clk);
    #1;

    // Reset coincident with a write edge: fill X1-X30 first.
    for (int i = 1; i < 31; i++) begin
      drive(5'd0, 5'd0, 5'(i), 64'h1111_0000_0000_0000 + 64'(i) * 64'h0101, 1'b1);
      edge_step();
    end
    drive(5'd3, 5'd30, 5'd0, '0, 1'b0);
    #1;
    check_all4("filled", 64'h1111_0000_0000_0303, 64'h1111_0000_0000_1E1E,
               64'h1111_0000_0000_0303, 64'h1111_0000_0000_1E1E);
    edge_step();
    drive(5'd3, 5'd3, 5'd3, 64'h55, 1'b1);
    set_reset(1'b1);
    #1;
    check_all4("rst_wr_pre", 64'h0, 64'h0, RV_N, RV_N);
    edge_step();
    for (int i = 0; i < 32; i++) begin
      drive(5'(i), 5'(31 - i), 5'd3, 64'h55, 1'b1);
      #1;
      check_model("rst_wr_scan");
    end
    @(posedge clk);
    #1;
    set_reset(1'b0);
    drive(5'd3, 5'd4, 5'd3, 64'h77, 1'b1);
    #1;
    check_all4("post_rst_wr", 64'h77, 64'h0, RV_N, RV_N);
    edge_step();
    drive(5'd3, 5'd3, 5'd3, 64'h0, 1'b0);
    #1;
    check_all4("post_rst_rd", 64'h77, 64'h77, 64'h77, 64'h77);
    edge_step();

    // Randomized run against the model, with collisions and XZR biased in.
    for (int n = 0; n < 1000; n++) begin
      w = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
      d = {$urandom, $urandom};
      drive(a, b, w, d, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) == 0) set_reset(1'b1);
      #1;
      check_model("rand");
      edge_step();
      if (reset) set_reset(1'b0);
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
